// File: rtl/hms_clock_core.sv
// hms_clock_core: HH:MM:SS timekeeper with synchronised/debounced set/up/down buttons and
// registered active-low 7-segment outputs. Optional `define BLINK_EN blanks the field being set.
module hms_clock_core #(
  parameter int unsigned TICK_DIV   = 50000000,
  parameter int unsigned DEB_CYCLES = 250000,
  parameter int unsigned MAX_HOUR   = 23,
  parameter int unsigned BLINK_DIV  = 12500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       set,
  input  logic       up,
  input  logic       down,
  output logic [6:0] disp0,
  output logic [6:0] disp1,
  output logic [6:0] disp2,
  output logic [6:0] disp3,
  output logic [6:0] disp4,
  output logic [6:0] disp5,
  output logic [1:0] mode,
  output logic       sec_tick
);

  localparam int unsigned TickW = $clog2(TICK_DIV);
  localparam int unsigned DebW  = $clog2(DEB_CYCLES + 1);
  localparam logic [6:0]  HourMax = 7'(MAX_HOUR);
  localparam int unsigned BtnSet = 0;
  localparam int unsigned BtnUp  = 1;
  localparam int unsigned BtnDn  = 2;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StSetHour = 2'd1,
    StSetMin  = 2'd2,
    StSetSec  = 2'd3
  } mode_e;

  function automatic logic [6:0] seg7(input logic [6:0] v);
    logic [6:0] s;
    case (v)
      7'd0:    s = 7'h40;
      7'd1:    s = 7'h79;
      7'd2:    s = 7'h24;
      7'd3:    s = 7'h30;
      7'd4:    s = 7'h19;
      7'd5:    s = 7'h12;
      7'd6:    s = 7'h02;
      7'd7:    s = 7'h78;
      7'd8:    s = 7'h00;
      7'd9:    s = 7'h10;
      default: s = 7'h7f;
    endcase
    return s;
  endfunction

  // Button front-end
  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      level_q, level_d, level_dly_q;
  logic [2:0]      pulse_q, pulse_d;
  logic [DebW-1:0] deb_cnt_q [3];
  logic [DebW-1:0] deb_cnt_d [3];

  assign btn_raw = {down, up, set};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      level_d[i]   = level_q[i];
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (deb_cnt_q[i] == DebW'(DEB_CYCLES - 1)) begin
          level_d[i] = ~level_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
    // Pulse lands in the cycle after the debounced level has risen.
    pulse_d = level_q & ~level_dly_q;
  end

  logic set_p, up_p, dn_p;
  assign set_p = pulse_q[BtnSet];
  assign up_p  = pulse_q[BtnUp];
  assign dn_p  = pulse_q[BtnDn];

  // Tick, mode and time
  logic [TickW-1:0] tick_q, tick_d;
  mode_e            mode_q, mode_d;
  logic [6:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d, ss_q, ss_d;

  assign sec_tick = (tick_q == TickW'(TICK_DIV - 1));
  assign mode     = mode_q;

  always_comb begin
    mode_d = mode_q;
    hh_d   = hh_q;
    mm_d   = mm_q;
    ss_d   = ss_q;
    tick_d = sec_tick ? '0 : tick_q + TickW'(1);

    if (set_p) begin
      unique case (mode_q)
        StRun:     mode_d = StSetHour;
        StSetHour: mode_d = StSetMin;
        StSetMin:  mode_d = StSetSec;
        StSetSec:  mode_d = StRun;
        default:   mode_d = StRun;
      endcase
    end

    // Leaving set mode restarts the second so the first one is full length.
    if (mode_q == StSetSec && mode_d == StRun) begin
      tick_d = '0;
    end

    if (mode_q == StRun) begin
      if (sec_tick) begin
        if (ss_q == 6'd59) begin
          ss_d = '0;
          if (mm_q == 6'd59) begin
            mm_d = '0;
            hh_d = (hh_q == HourMax) ? '0 : hh_q + 7'd1;
          end else begin
            mm_d = mm_q + 6'd1;
          end
        end else begin
          ss_d = ss_q + 6'd1;
        end
      end
    end else if (!set_p && (up_p ^ dn_p)) begin
      unique case (mode_q)
        StSetHour: begin
          if (up_p) hh_d = (hh_q == HourMax) ? '0 : hh_q + 7'd1;
          else      hh_d = (hh_q == '0) ? HourMax : hh_q - 7'd1;
        end
        StSetMin: begin
          if (up_p) mm_d = (mm_q == 6'd59) ? '0 : mm_q + 6'd1;
          else      mm_d = (mm_q == '0) ? 6'd59 : mm_q - 6'd1;
        end
        StSetSec: begin
          if (up_p) ss_d = (ss_q == 6'd59) ? '0 : ss_q + 6'd1;
          else      ss_d = (ss_q == '0) ? 6'd59 : ss_q - 6'd1;
        end
        default: ;
      endcase
    end
  end

  // Blink of the selected field
  logic blink_on;

`ifdef BLINK_EN
  localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  logic              blink_q, blink_d;

  always_comb begin
    blink_cnt_d = blink_cnt_q + BlinkW'(1);
    blink_d     = blink_q;
    if (|pulse_q) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      blink_d     = ~blink_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b0;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end

  assign blink_on = blink_q;
`else
  logic unused_blink_div;
  assign unused_blink_div = ^BLINK_DIV;
  assign blink_on         = 1'b0;
`endif

  // Display
  logic [6:0] disp_q [6];
  logic [6:0] disp_d [6];
  logic [6:0] mm_ext, ss_ext;

  assign mm_ext = {1'b0, mm_q};
  assign ss_ext = {1'b0, ss_q};

  always_comb begin
    disp_d[0] = seg7(ss_ext % 7'd10);
    disp_d[1] = seg7(ss_ext / 7'd10);
    disp_d[2] = seg7(mm_ext % 7'd10);
    disp_d[3] = seg7(mm_ext / 7'd10);
    disp_d[4] = seg7(hh_q % 7'd10);
    disp_d[5] = seg7(hh_q / 7'd10);
    if (blink_on) begin
      unique case (mode_q)
        StSetSec: begin
          disp_d[0] = 7'h7f;
          disp_d[1] = 7'h7f;
        end
        StSetMin: begin
          disp_d[2] = 7'h7f;
          disp_d[3] = 7'h7f;
        end
        StSetHour: begin
          disp_d[4] = 7'h7f;
          disp_d[5] = 7'h7f;
        end
        default: ;
      endcase
    end
  end

  assign disp0 = disp_q[0];
  assign disp1 = disp_q[1];
  assign disp2 = disp_q[2];
  assign disp3 = disp_q[3];
  assign disp4 = disp_q[4];
  assign disp5 = disp_q[5];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= '0;
      tick_q      <= '0;
      mode_q      <= StRun;
      hh_q        <= '0;
      mm_q        <= '0;
      ss_q        <= '0;
      for (int i = 0; i < 6; i++) disp_q[i] <= 7'h40;
    end else begin
      sync1_q     <= btn_raw;
      sync2_q     <= sync1_q;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
      for (int i = 0; i < 3; i++) deb_cnt_q[i] <= deb_cnt_d[i];
      tick_q      <= tick_d;
      mode_q      <= mode_d;
      hh_q        <= hh_d;
      mm_q        <= mm_d;
      ss_q        <= ss_d;
      for (int i = 0; i < 6; i++) disp_q[i] <= disp_d[i];
    end
  end

endmodule

// File: tb/tb_hms_clock_core.sv
// Directed bench for hms_clock_core with TICK_DIV=4, DEB_CYCLES=3, MAX_HOUR=23, BLINK_DIV=2.
module tb_hms_clock_core;

  logic       clk = 1'b0;
  logic       reset, set, up, down;
  logic [6:0] disp0, disp1, disp2, disp3, disp4, disp5;
  logic [1:0] mode;
  logic       sec_tick;

  int errors = 0;
  int checks = 0;
  int n;
  logic [6:0] seg_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  hms_clock_core #(
    .TICK_DIV  (4),
    .DEB_CYCLES(3),
    .MAX_HOUR  (23),
    .BLINK_DIV (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .set     (set),
    .up      (up),
    .down    (down),
    .disp0   (disp0),
    .disp1   (disp1),
    .disp2   (disp2),
    .disp3   (disp3),
    .disp4   (disp4),
    .disp5   (disp5),
    .mode    (mode),
    .sec_tick(sec_tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int hh, input int mm, input int ss);
    check($sformatf("%s.disp5", tag), {1'b0, disp5}, {1'b0, seg_lut[hh / 10]});
    check($sformatf("%s.disp4", tag), {1'b0, disp4}, {1'b0, seg_lut[hh % 10]});
    check($sformatf("%s.disp3", tag), {1'b0, disp3}, {1'b0, seg_lut[mm / 10]});
    check($sformatf("%s.disp2", tag), {1'b0, disp2}, {1'b0, seg_lut[mm % 10]});
    check($sformatf("%s.disp1", tag), {1'b0, disp1}, {1'b0, seg_lut[ss / 10]});
    check($sformatf("%s.disp0", tag), {1'b0, disp0}, {1'b0, seg_lut[ss % 10]});
  endtask

  task automatic press(input logic s, input logic u, input logic d, input int hold);
    @(negedge clk);
    set  = s;
    up   = u;
    down = d;
    repeat (hold) @(negedge clk);
    set  = 1'b0;
    up   = 1'b0;
    down = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    set   = 1'b0;
    up    = 1'b0;
    down  = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_mode", 8'(mode), 8'd0);
    check("reset_tick", 8'(sec_tick), 8'd0);
    check_time("reset", 0, 0, 0);

    // Free-running tick: strobe when the counter reaches 3.
    reset = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      check($sformatf("tick%0d", k), 8'(sec_tick), 8'((k % 4) == 3));
    end
    @(negedge clk);
    check_time("four_ticks", 0, 0, 4);

    // Set held through reset: debounces afresh, enters SET_HOUR at the 7th edge.
    reset = 1'b1;
    set   = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("enter_pre", 8'(mode), 8'd0);
    @(posedge clk);
    #1 check("enter_hour", 8'(mode), 8'd1);
    @(negedge clk);
    set = 1'b0;
    repeat (10) @(negedge clk);
    check_time("hour_entry", 0, 0, 1);

    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (sec_tick) n++;
    end
    check("set_ticks", 8'(n), 8'd2);
    check_time("frozen", 0, 0, 1);

    press(1'b0, 1'b0, 1'b1, 10);
    check_time("hour_down_wrap", 23, 0, 1);
    press(1'b0, 1'b1, 1'b0, 10);
    check_time("hour_up_wrap", 0, 0, 1);
    press(1'b0, 1'b0, 1'b1, 10);
    check_time("hour_back", 23, 0, 1);

    press(1'b1, 1'b0, 1'b0, 10);
    check("mode_min", 8'(mode), 8'd2);
    press(1'b0, 1'b1, 1'b0, 2);
    check_time("min_glitch", 23, 0, 1);
    press(1'b0, 1'b1, 1'b0, 10);
    check_time("min_up", 23, 1, 1);
    press(1'b0, 1'b0, 1'b1, 10);
    press(1'b0, 1'b0, 1'b1, 10);
    check_time("min_down_wrap", 23, 59, 1);

    press(1'b1, 1'b0, 1'b0, 10);
    check("mode_sec", 8'(mode), 8'd3);
    press(1'b0, 1'b0, 1'b1, 10);
    check_time("sec_down", 23, 59, 0);
    press(1'b0, 1'b0, 1'b1, 10);
    check_time("sec_down_wrap", 23, 59, 59);
    press(1'b0, 1'b1, 1'b1, 10);
    check_time("sec_up_down", 23, 59, 59);

    // Set with up: back to RUN, up dropped, first tick a full TICK_DIV later.
    @(negedge clk);
    set = 1'b1;
    up  = 1'b1;
    repeat (7) @(posedge clk);
    #1 check("mode_run", 8'(mode), 8'd0);
    @(posedge clk);
    #1 check("reentry_t1", 8'(sec_tick), 8'd0);
    @(posedge clk);
    #1 check("reentry_t2", 8'(sec_tick), 8'd0);
    @(posedge clk);
    #1 check("reentry_t3", 8'(sec_tick), 8'd1);
    @(posedge clk);
    #1 check("reentry_t4", 8'(sec_tick), 8'd0);
    check_time("before_roll", 23, 59, 59);
    @(posedge clk);
    #1 check_time("rollover", 0, 0, 0);
    @(negedge clk);
    set = 1'b0;
    up  = 1'b0;

    // Asynchronous reset in the middle of a set debounce.
    repeat (3) @(negedge clk);
    set = 1'b1;
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    #1 check("async_mode", 8'(mode), 8'd0);
    check_time("async_reset", 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("afresh_wait", 8'(mode), 8'd0);
    @(posedge clk);
    #1 check("afresh_pulse", 8'(mode), 8'd1);
`ifdef BLINK_EN
    for (int j = 8; j <= 15; j++) begin
      logic [7:0] hexp;
      @(posedge clk);
      #1;
      hexp = (j == 10 || j == 11 || j == 14 || j == 15) ? 8'h7f : 8'h40;
      check($sformatf("blink%0d.disp5", j), {1'b0, disp5}, hexp);
      check($sformatf("blink%0d.disp4", j), {1'b0, disp4}, hexp);
      check($sformatf("blink%0d.disp2", j), {1'b0, disp2}, 8'h40);
      check($sformatf("blink%0d.disp0", j), {1'b0, disp0}, 8'h79);
    end
`endif
    repeat (20) @(negedge clk);
    check("held_once", 8'(mode), 8'd1);
    #2 reset = 1'b1;
    #1 check("midop_mode", 8'(mode), 8'd0);
    check_time("midop_reset", 0, 0, 0);
    @(negedge clk);
    set   = 1'b0;
    reset = 1'b0;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
